reg_cmd_ctrl: RTL
=================

# reg_cmd_ctrl

Command-frame controller between the UART receiver and the 16x8 register file. Parses byte frames from the UART RX parallel output, issues single-cycle write or read strobes to the register file, and forwards read data to the UART TX parallel input over a valid/busy handshake. It is the only master of the register-file write/read port.

## Interface
- WIDTH, 8, data and frame byte width
- ADDR_SIZE, 4, register-file address width (DEPTH = 2^ADDR_SIZE)
- TIMEOUT, 4, cycles to wait for RdData_Valid after RdEn before aborting
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  reset, asynchronous and active-high
- RX_P_Data  in  WIDTH  received byte
- RX_D_VLD  in  1  one-cycle strobe, RX_P_Data valid
- WrEn  out  1  register-file write strobe
- RdEn  out  1  register-file read strobe
- Address  out  ADDR_SIZE  register-file address
- WrData  out  WIDTH  register-file write data
- RdData  in  WIDTH  register-file read data
- RdData_Valid  in  1  read data valid strobe from register file
- TX_P_Data  out  WIDTH  byte to transmit
- TX_D_VLD  out  1  TX_P_Data valid, held until accepted
- TX_Busy  in  1  transmitter busy; byte accepted on TX_D_VLD && !TX_Busy
- Cmd_Err  out  1  one-cycle error pulse

## Operation
- Frames: write = 0xAA, addr, data; read = 0xBB, addr. Bytes consumed only on cycles with RX_D_VLD=1.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND.
- IDLE: 0xAA -> WR_ADDR; 0xBB -> RD_ADDR; any other byte -> Cmd_Err pulse, stay IDLE.
- WR_ADDR/RD_ADDR: byte[ADDR_SIZE-1:0] latched into Address; if byte[WIDTH-1:ADDR_SIZE] != 0 -> Cmd_Err, IDLE, no strobe. Else WR_ADDR -> WR_DATA; RD_ADDR -> RdEn pulse, RD_WAIT.
- WR_DATA: byte latched into WrData, WrEn pulse, -> IDLE.
- RD_WAIT: on RdData_Valid latch RdData into TX_P_Data, -> TX_SEND. Timeout counter starts at 0 on entry; after TIMEOUT cycles without RdData_Valid -> Cmd_Err, IDLE.
- TX_SEND: TX_D_VLD=1, TX_P_Data stable until TX_D_VLD && !TX_Busy; then -> IDLE.
- RX_D_VLD in RD_WAIT or TX_SEND: byte discarded, Cmd_Err pulse, state unchanged.
- WrEn and RdEn never high in the same cycle; each high for exactly one cycle per accepted frame.
- Address and WrData hold last value between frames.

## Timing
- Reset (RST=1, async): state IDLE, WrEn=0, RdEn=0, Address=0, WrData=0, TX_P_Data=0, TX_D_VLD=0, Cmd_Err=0, timeout counter=0.
- RST asserted mid-frame: frame abandoned, no strobe issued, outputs to reset values immediately.
- All outputs registered.
- Write: data byte accepted at edge N -> WrEn=1 with Address/WrData valid in cycle N+1; IDLE accepts a new byte in cycle N+1.
- Read: addr byte at edge N -> RdEn=1 in cycle N+1; RdData_Valid expected cycle N+2; TX_D_VLD=1 from cycle N+3.
- Handshake: TX_D_VLD falls the cycle after the accept edge; back-to-back read frames emit one TX byte each.
- Cmd_Err asserts in the cycle after the offending byte/timeout edge, one cycle wide.

## Test plan
- Reset, send AA,05,3C -> single WrEn pulse, Address=5, WrData=0x3C; no Cmd_Err.
- Preload reg 3=0x08, send BB,03, TX_Busy=0 -> RdEn one cycle, TX_D_VLD with TX_P_Data=0x08 for one cycle.
- Send BB,02 with TX_Busy=1 for 10 cycles -> TX_D_VLD held, TX_P_Data stable, dropped 1 cycle after TX_Busy falls.
- Send 0x55 in IDLE; send AA,15 -> Cmd_Err pulses, no WrEn, state IDLE; subsequent AA,01,FF writes correctly.
- Tie RdData_Valid=0, send BB,01 -> Cmd_Err exactly TIMEOUT cycles after RdEn, no TX_D_VLD.
- Assert RST after AA,07 -> no WrEn; after release BB,07 returns value unchanged from before the frame.

Source files
------------

// File: rtl/reg_cmd_ctrl.sv
// Command-frame controller: parses UART RX byte frames (AA addr data / BB addr)
// into register-file write/read strobes and returns read data over the TX handshake.
module reg_cmd_ctrl #(
  parameter int WIDTH     = 8,
  parameter int ADDR_SIZE = 4,
  parameter int TIMEOUT   = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [WIDTH-1:0]     RX_P_Data,
  input  logic                 RX_D_VLD,
  output logic                 WrEn,
  output logic                 RdEn,
  output logic [ADDR_SIZE-1:0] Address,
  output logic [WIDTH-1:0]     WrData,
  input  logic [WIDTH-1:0]     RdData,
  input  logic                 RdData_Valid,
  output logic [WIDTH-1:0]     TX_P_Data,
  output logic                 TX_D_VLD,
  input  logic                 TX_Busy,
  output logic                 Cmd_Err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]    TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] CMD_WR  = WIDTH'('hAA);
  localparam logic [WIDTH-1:0] CMD_RD  = WIDTH'('hBB);

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND} state_t;

  state_t               state, nxt;
  logic [CW-1:0]        cnt, cnt_d;
  logic                 wr_d, rd_d, err_d, txv_d;
  logic [ADDR_SIZE-1:0] addr_d;
  logic [WIDTH-1:0]     wd_d, txd_d;
  logic                 addr_ok, timeout;

  assign addr_ok = (RX_P_Data[WIDTH-1:ADDR_SIZE] == '0);
  assign timeout = (state == RD_WAIT) && !RdData_Valid && (cnt == TO_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      Cmd_Err   <= 1'b0;
      TX_D_VLD  <= 1'b0;
      Address   <= '0;
      WrData    <= '0;
      TX_P_Data <= '0;
    end else begin
      state     <= nxt;
      cnt       <= cnt_d;
      WrEn      <= wr_d;
      RdEn      <= rd_d;
      Cmd_Err   <= err_d;
      TX_D_VLD  <= txv_d;
      Address   <= addr_d;
      WrData    <= wd_d;
      TX_P_Data <= txd_d;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (RX_D_VLD) begin
                 if (RX_P_Data == CMD_WR)      nxt = WR_ADDR;
                 else if (RX_P_Data == CMD_RD) nxt = RD_ADDR;
               end
      WR_ADDR: if (RX_D_VLD) nxt = addr_ok ? WR_DATA : IDLE;
      RD_ADDR: if (RX_D_VLD) nxt = addr_ok ? RD_WAIT : IDLE;
      WR_DATA: if (RX_D_VLD) nxt = IDLE;
      RD_WAIT: if (RdData_Valid) nxt = TX_SEND;
               else if (timeout) nxt = IDLE;
      // TX_D_VLD is high throughout TX_SEND, so !TX_Busy alone marks the accept
      TX_SEND: if (!TX_Busy) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs
  always_comb begin
    wr_d   = 1'b0;
    rd_d   = 1'b0;
    err_d  = 1'b0;
    addr_d = Address;
    wd_d   = WrData;
    txd_d  = TX_P_Data;
    txv_d  = (nxt == TX_SEND);
    cnt_d  = (state == RD_WAIT && nxt == RD_WAIT) ? cnt + 1'b1 : '0;
    case (state)
      IDLE: if (RX_D_VLD && RX_P_Data != CMD_WR && RX_P_Data != CMD_RD) err_d = 1'b1;
      WR_ADDR, RD_ADDR: if (RX_D_VLD) begin
        addr_d = RX_P_Data[ADDR_SIZE-1:0];
        if (!addr_ok)               err_d = 1'b1;
        else if (state == RD_ADDR) rd_d  = 1'b1;
      end
      WR_DATA: if (RX_D_VLD) begin
        wd_d = RX_P_Data;
        wr_d = 1'b1;
      end
      RD_WAIT: begin
        if (RX_D_VLD)          err_d = 1'b1;
        if (RdData_Valid)      txd_d = RdData;
        else if (timeout)      err_d = 1'b1;
      end
      TX_SEND: if (RX_D_VLD) err_d = 1'b1;
      default: ;
    endcase
  end

endmodule
